// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for one shared resource, fed by request strobes from a foreign clock domain.
// Each request edge is synchronised, latched as a pending event and granted once, with a watchdog on the hold time.
module async_req_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDX_W         = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_async,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] pending,
  output logic             timeout
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
  logic [N_REQ-1:0] prev_q;
  logic [N_REQ-1:0] rise;

  state_t           state, state_d;
  logic [N_REQ-1:0] grant_d, pending_d, clear, sel_onehot;
  logic             grant_valid_d, timeout_d, sel_found;
  logic [IDX_W-1:0] grant_idx_d, last_idx, last_idx_d, sel, cand;
  logic [TMR_W-1:0] timer, timer_d;

  // Synchroniser chain plus one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Round-robin pick: first pending bit after the last granted index
  always_comb begin
    sel       = last_idx;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_idx) + k) % N_REQ);
      if (!sel_found && pending[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
    sel_onehot = N_REQ'(1) << sel;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state;
    grant_d       = grant;
    grant_valid_d = grant_valid;
    grant_idx_d   = grant_idx;
    timeout_d     = 1'b0;
    timer_d       = timer;
    last_idx_d    = last_idx;
    clear         = '0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          grant_d       = sel_onehot;
          grant_valid_d = 1'b1;
          grant_idx_d   = sel;
          last_idx_d    = sel;
          timer_d       = '0;
          clear         = sel_onehot;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        timer_d = timer + TMR_W'(1);
        if (done) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          state_d       = S_RELEASE;
        end else if (timer == TMR_LAST) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timeout_d     = 1'b1;
          state_d       = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // A rise coinciding with selection re-queues the event
    pending_d = (pending & ~clear) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      pending     <= '0;
      timeout     <= 1'b0;
      timer       <= '0;
      last_idx    <= LAST_INIT;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      grant_idx   <= grant_idx_d;
      pending     <= pending_d;
      timeout     <= timeout_d;
      timer       <= timer_d;
      last_idx    <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_async_req_arbiter.sv
// Self-checking bench for async_req_arbiter: directed scenarios plus random traffic against an event-level model.
module tb_async_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         done = 1'b0;
  logic [N-1:0] req_async = '0;
  logic [N-1:0] grant, pending;
  logic         grant_valid, timeout;
  logic [1:0]   grant_idx;
  logic [11:0]  act;

  int errors = 0;
  int checks = 0;

  async_req_arbiter #(.N_REQ(N), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_async(req_async), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .pending(pending), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign act = {grant, grant_valid, grant_idx, pending, timeout};

  // Event-level reference: sample history, owner, hold count, cooldown edges
  int           m_owner, m_last, m_idx, m_held, m_gap, m_best, m_bestd, m_d;
  logic [N-1:0] m_pend, m_old;
  logic         m_to;
  logic [N-1:0] m_hist [S+2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1; m_last = N - 1; m_idx = 0; m_held = 0; m_gap = 0;
      m_pend = '0; m_to = 1'b0;
      for (int k = 0; k < S + 2; k++) m_hist[k] = '0;
    end else begin
      m_old = m_pend;
      m_to  = 1'b0;
      for (int k = S + 1; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = req_async;
      if (m_owner >= 0) begin
        if (done) begin
          m_owner = -1; m_gap = 1;
        end else if (m_held == TO) begin
          m_owner = -1; m_gap = 1; m_to = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_old != '0) begin
        m_best = 0; m_bestd = N;
        for (int i = 0; i < N; i++) begin
          m_d = (i - m_last - 1 + 2 * N) % N;
          if (m_old[i] && m_d < m_bestd) begin m_bestd = m_d; m_best = i; end
        end
        m_pend[m_best] = 1'b0;
        m_owner = m_best; m_last = m_best; m_idx = m_best; m_held = 1;
      end
      for (int i = 0; i < N; i++)
        if (m_hist[S][i] && !m_hist[S+1][i]) m_pend[i] = 1'b1;
    end
  end

  function automatic logic [11:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    return {g, (m_owner >= 0), 2'(m_idx), m_pend, m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int got[$];
  int max_hc, to_cnt, min_gap, mdl_bad;

  task automatic do_reset();
    reset = 1'b0; req_async = '0; done = 1'b0;
    tick(); tick();
    reset = 1'b1;
    got.delete();
    mdl_bad = 0;
  endtask

  // Acts as the resource: answers each grant with done after 'hold' cycles (0 = never)
  task automatic serve(input int n, input int hold, input int budget);
    int hc, lc;
    hc = 0; lc = 1000; max_hc = 0; to_cnt = 0; min_gap = 1000;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (act !== exp_vec()) mdl_bad++;
      if (timeout) to_cnt++;
      if (grant_valid) begin
        if (hc == 0) begin
          got.push_back(int'(grant_idx));
          if (lc < min_gap) min_gap = lc;
        end
        hc++; lc = 0;
        if (hc > max_hc) max_hc = hc;
      end else begin
        hc = 0; lc++;
      end
      done = (hold > 0 && grant_valid && hc == hold);
      if (got.size() >= n && !grant_valid && lc >= 3) break;
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_async = '1; done = 1'b0;
    tick(); tick();
    checks++;
    if (act !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h want 000", act); end
    req_async = '0;
    reset = 1'b1;
    tick();
    checks++;
    if (act !== exp_vec()) begin errors++; $display("FAIL reset_release: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_single();
    do_reset();
    req_async = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL single_c%0d: got %h want %h", c, act, exp_vec()); end
      if (c == 2) req_async = '0;
      done = (c == 7);
      if (c == 1) begin
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL single_pend_early: got %b want 0000", pending); end
      end
      if (c == 2) begin
        checks++;
        if ({pending, grant} !== 8'b0001_0000) begin errors++; $display("FAIL single_pend: got %b want 00010000", {pending, grant}); end
      end
      if (c == 3) begin
        checks++;
        if ({grant, grant_valid, grant_idx, pending} !== 11'b0001_1_00_0000) begin
          errors++; $display("FAIL single_grant: got %b want 00011000000", {grant, grant_valid, grant_idx, pending});
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL single_release_c%0d: got %b want 0000", c, grant); end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_async = '1;
    tick(); tick();
    req_async = '0;
    serve(4, 3, 200);
    checks++;
    if (got.size() != 4 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3) begin
      errors++; $display("FAIL simul_order: got %p want 0 1 2 3", got);
    end
    checks++;
    if (min_gap < 2 || max_hc != 3) begin errors++; $display("FAIL simul_gap_hold: got gap %0d hold %0d want gap>=2 hold 3", min_gap, max_hc); end
    checks++;
    if (mdl_bad != 0) begin errors++; $display("FAIL simul_model: got %0d bad cycles want 0", mdl_bad); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_async = 4'b0100;
    tick(); tick();
    req_async = '0;
    serve(1, 2, 50);
    got.delete();
    req_async = 4'b1010;
    tick(); tick();
    req_async = '0;
    serve(2, 2, 60);
    checks++;
    if (got.size() != 2 || got[0] != 3 || got[1] != 1) begin errors++; $display("FAIL rr_order: got %p want 3 1", got); end
    checks++;
    if (mdl_bad != 0) begin errors++; $display("FAIL rr_model: got %0d bad cycles want 0", mdl_bad); end
  endtask

  task automatic test_watchdog();
    do_reset();
    req_async = 4'b0010;
    tick(); tick();
    req_async = '0;
    serve(1, 0, 60);
    checks++;
    if (got.size() != 1 || got[0] != 1) begin errors++; $display("FAIL wd_grant: got %p want 1", got); end
    checks++;
    if (max_hc != TO || to_cnt != 1) begin errors++; $display("FAIL wd_timing: got hold %0d pulses %0d want 16 1", max_hc, to_cnt); end
    checks++;
    if (mdl_bad != 0 || grant_valid !== 1'b0) begin errors++; $display("FAIL wd_idle: got bad %0d valid %b want 0 0", mdl_bad, grant_valid); end
  endtask

  task automatic test_collisions();
    // done on the same edge the watchdog would fire
    do_reset();
    req_async = 4'b0001;
    tick(); tick();
    req_async = '0;
    serve(1, TO, 60);
    checks++;
    if (to_cnt != 0 || max_hc != TO || mdl_bad != 0) begin
      errors++; $display("FAIL coll_done_to: got pulses %0d hold %0d bad %0d want 0 16 0", to_cnt, max_hc, mdl_bad);
    end
    // fresh rise on the granted line
    do_reset();
    req_async = 4'b0101;
    tick(); tick();
    req_async = '0;
    tick(); tick();
    req_async = 4'b0001;
    tick(); tick();
    req_async = '0;
    serve(3, 5, 150);
    checks++;
    if (got.size() != 3 || got[0] != 0 || got[1] != 2 || got[2] != 0 || mdl_bad != 0) begin
      errors++; $display("FAIL coll_regrant: got %p bad %0d want 0 2 0 bad 0", got, mdl_bad);
    end
    // rise lands on the same edge its bit is selected
    do_reset();
    req_async = 4'b0011;
    tick(); tick();
    req_async = '0;
    tick(); tick();
    done = 1'b1; req_async = 4'b0010;
    tick();
    done = 1'b0;
    tick();
    req_async = '0;
    tick();
    checks++;
    if ({grant, pending} !== 8'b0010_0010) begin errors++; $display("FAIL coll_select_rise: got %b want 00100010", {grant, pending}); end
    serve(2, 2, 60);
    checks++;
    if (got.size() != 2 || got[0] != 1 || got[1] != 1 || mdl_bad != 0) begin
      errors++; $display("FAIL coll_select_regrant: got %p bad %0d want 1 1 bad 0", got, mdl_bad);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_async = 4'b0111;
    tick(); tick();
    req_async = '0;
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if ({grant, pending} !== 8'b0001_0110) begin errors++; $display("FAIL rstmid_setup: got %b want 00010110", {grant, pending}); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({grant, grant_valid, pending, timeout} !== 10'b0) begin
      errors++; $display("FAIL rstmid_async: got %b want 0000000000", {grant, grant_valid, pending, timeout});
    end
    tick(); tick();
    reset = 1'b1;
    got.delete(); mdl_bad = 0;
    req_async = 4'b1001;
    tick(); tick();
    req_async = '0;
    serve(2, 2, 60);
    checks++;
    if (got.size() < 1 || got[0] != 0 || mdl_bad != 0) begin errors++; $display("FAIL rstmid_priority: got %p bad %0d want first 0", got, mdl_bad); end
  endtask

  task automatic test_random();
    int hc;
    do_reset();
    hc = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random_c%0d: got %h want %h", c, act, exp_vec()); end
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) req_async[i] = ~req_async[i];
      hc = grant_valid ? hc + 1 : 0;
      done = grant_valid ? ($urandom_range(4) == 0) : ($urandom_range(7) == 0);
    end
    done = 1'b0;
    req_async = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_watchdog();
    test_collisions();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
